hdlc_rx_deframer: RTL



---
 rtl/hdlc_pkg.sv | 17 +
 rtl/hdlc_rx_flagdet.sv | 52 +++++
 rtl/hdlc_rx_deframer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hdlc_pkg.sv
// HDLC receive constants and shared state type.
// Latency: n/a (no logic).
// Backpressure: n/a.
package hdlc_pkg;

  // Opening/closing flag, identical in either bit order.
  localparam logic [7:0]  FLAG       = 8'h7E;
  // A zero following this many data ones was inserted by the transmitter.
  localparam int unsigned STUFF_ONES = 5;
  // This many consecutive raw ones inside a frame is an abort sequence.
  localparam int unsigned ABORT_ONES = 7;
  // Number of line bits a flag occupies in the delay line.
  localparam int unsigned FLAG_LEN   = 8;

  typedef enum logic {HUNT, FRAME} rx_state_t;

endpackage

// File: rtl/hdlc_rx_flagdet.sv
// Raw-line front end: 8-bit delay line, raw ones run and flag-bit discard window.
// Latency: flag/abort are combinational on the enabled bit; o_dbit lags i_rx by 8 enabled bits.
// Backpressure: none; state advances only when i_en is high and holds otherwise.
module hdlc_rx_flagdet
  import hdlc_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  input  logic i_en,
  output logic o_dbit,
  output logic o_dvld,
  output logic o_flag,
  output logic o_abort
);

  logic [7:0] r_dly;
  logic [2:0] r_ones;
  logic [3:0] r_disc;
  logic [7:0] w_dly_nxt;

  // Oldest bit sits at r_dly[0] and is the one leaving on the next shift.
  assign w_dly_nxt = {i_rx, r_dly[7:1]};
  assign o_dbit    = r_dly[0];
  // Leaving bits are flag bits while the discard window is open.
  assign o_dvld    = i_en && (r_disc == 4'd0);
  assign o_flag    = i_en && (w_dly_nxt == FLAG);
  // Fires only on the transition to the abort count, never while saturated.
  assign o_abort   = i_en && i_rx && (r_ones == 3'(ABORT_ONES - 1));

  // Shift the line, track the raw ones run and reopen the discard window on each flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dly  <= '0;
      r_ones <= '0;
      r_disc <= '0;
    end else if (i_en) begin
      r_dly <= w_dly_nxt;
      if (!i_rx) begin
        r_ones <= '0;
      end else if (r_ones != 3'(ABORT_ONES)) begin
        r_ones <= r_ones + 3'd1;
      end
      if (o_flag) begin
        r_disc <= 4'(FLAG_LEN);
      end else if (r_disc != 4'd0) begin
        r_disc <= r_disc - 4'd1;
      end
    end
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag hunt, zero destuffing, LSB-first byte assembly, frame events.
// Latency: events one cycle after the enabled bit that completes them; bytes 8 enabled bits + 1 cycle after their last bit.
// Backpressure: none; RxEN gaps freeze all state, only the one-cycle pulses drop.
module hdlc_rx_deframer
  import hdlc_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_ValidFrame,
  output logic       Rx_FlagDetect,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic       Rx_AbortSignal,
  output logic [7:0] Rx_FrameSize
);

  rx_state_t  r_state;
  logic [6:0] r_shift;
  logic [2:0] r_bitcnt;
  logic [2:0] r_dones;

  logic       w_dbit;
  logic       w_dvld;
  logic       w_flag;
  logic       w_abort;
  logic       w_stuff;
  logic       w_take;
  logic       w_byte_done;
  logic       w_has_bytes;
  logic [7:0] w_byte;
  logic [2:0] w_bitcnt_nxt;
  logic [2:0] w_dones_nxt;
  logic [7:0] w_size_nxt;

  hdlc_rx_flagdet u_flagdet (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_rx    (Rx),
    .i_en    (RxEN),
    .o_dbit  (w_dbit),
    .o_dvld  (w_dvld),
    .o_flag  (w_flag),
    .o_abort (w_abort)
  );

  // Destuff and assemble the bit leaving the delay line; it always precedes any flag now in the line.
  always_comb begin
    w_stuff      = w_dvld && !w_dbit && (r_dones == 3'(STUFF_ONES));
    w_take       = w_dvld && !w_stuff;
    w_byte       = {w_dbit, r_shift};
    w_byte_done  = w_take && (r_bitcnt == 3'd7);
    w_bitcnt_nxt = r_bitcnt;
    if (w_take) begin
      w_bitcnt_nxt = r_bitcnt + 3'd1;
    end
    w_dones_nxt = r_dones;
    if (w_dvld) begin
      if (!w_dbit) begin
        w_dones_nxt = '0;
      end else if (r_dones != 3'd7) begin
        w_dones_nxt = r_dones + 3'd1;
      end
    end
    // A byte finishing alongside the closing flag still belongs to the frame being closed.
    w_has_bytes = Rx_ValidFrame || w_byte_done;
    // First byte after an idle/closed state restarts the count.
    if (!Rx_ValidFrame) begin
      w_size_nxt = 8'd1;
    end else if (Rx_FrameSize == 8'hFF) begin
      w_size_nxt = 8'hFF;
    end else begin
      w_size_nxt = Rx_FrameSize + 8'd1;
    end
  end

  // Receiver FSM with registered outputs; pulses self-clear every cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state        <= HUNT;
      r_shift        <= '0;
      r_bitcnt       <= '0;
      r_dones        <= '0;
      Rx_Data        <= '0;
      Rx_NewByte     <= 1'b0;
      Rx_ValidFrame  <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_FrameSize   <= '0;
    end else begin
      Rx_NewByte     <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      if (RxEN) begin
        Rx_FlagDetect <= w_flag;
        case (r_state)
          HUNT: begin
            if (w_flag) begin
              r_state      <= FRAME;
              r_bitcnt     <= '0;
              r_dones      <= '0;
              Rx_FrameSize <= '0;
            end
          end
          FRAME: begin
            if (w_abort) begin
              Rx_AbortSignal <= 1'b1;
              Rx_ValidFrame  <= 1'b0;
              r_bitcnt       <= '0;
              r_dones        <= '0;
              r_state        <= HUNT;
            end else begin
              r_dones  <= w_dones_nxt;
              r_bitcnt <= w_bitcnt_nxt;
              if (w_take) begin
                r_shift <= w_byte[7:1];
              end
              if (w_byte_done) begin
                Rx_Data       <= w_byte;
                Rx_NewByte    <= 1'b1;
                Rx_ValidFrame <= 1'b1;
                Rx_FrameSize  <= w_size_nxt;
              end
              // Flags between frames only resync; a flag after data closes the frame.
              if (w_flag) begin
                r_bitcnt <= '0;
                r_dones  <= '0;
                if (w_has_bytes) begin
                  Rx_EoF        <= 1'b1;
                  Rx_FrameError <= (w_bitcnt_nxt != 3'd0);
                  Rx_ValidFrame <= 1'b0;
                end
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule
